// File: rtl/hmmm_loader.sv
// Program loader for the hmmm core: turns a framed serial byte stream into
// address/data programming strobes and releases the core on a verified frame.
module hmmm_loader #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [15:0] user_in,
    output logic [15:0] core_in,
    output logic        core_pgrm_addr,
    output logic        core_pgrm_data,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WR_ADDR, S_WR_DATA, S_CSUM, S_START
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, addr_q, csum_q;
    logic [15:0]    word_q;
    logic [TW-1:0]  idle_q;
    logic           err_q;
    logic           rx_ready_q, pgrm_addr_q, pgrm_data_q, core_rst_q, done_q;

    logic accept, waiting, timeout;

    assign accept  = rx_valid & rx_ready_q;
    assign waiting = (state_q == S_COUNT) || (state_q == S_HI) ||
                     (state_q == S_LO)    || (state_q == S_CSUM);
    assign timeout = waiting && !accept && (idle_q == TIMEOUT_LAST);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept && rx_data == HEADER) state_d = S_COUNT;
            S_COUNT:   if (accept) state_d = S_HI;
            S_HI:      if (accept) state_d = S_LO;
            S_LO:      if (accept) state_d = S_WR_ADDR;
            S_WR_ADDR: state_d = S_WR_DATA;
            S_WR_DATA: state_d = (addr_q == cnt_q) ? S_CSUM : S_HI;
            S_CSUM:    if (accept) state_d = (rx_data == csum_q) ? S_START : S_IDLE;
            S_START:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (accept && rx_data == HEADER) err_q <= 1'b0;
                S_COUNT: if (accept) begin
                    cnt_q  <= rx_data;
                    addr_q <= '0;
                    csum_q <= rx_data;
                end
                S_HI: if (accept) begin
                    word_q[15:8] <= rx_data;
                    csum_q       <= csum_q ^ rx_data;
                end
                S_LO: if (accept) begin
                    word_q[7:0] <= rx_data;
                    csum_q      <= csum_q ^ rx_data;
                end
                S_WR_DATA: if (addr_q != cnt_q) addr_q <= addr_q + 8'd1;
                S_CSUM: if (accept && rx_data != csum_q) err_q <= 1'b1;
                default: ;
            endcase
            if (timeout) err_q <= 1'b1;
            // Idle count restarts on every accepted byte and outside the waiting states.
            if (waiting && !accept && !timeout) idle_q <= idle_q + TW'(1);
            else                                idle_q <= '0;
        end
    end

    // Handshake and strobes are registered from the next state; reset holds the core in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q  <= 1'b0;
            pgrm_addr_q <= 1'b0;
            pgrm_data_q <= 1'b0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            rx_ready_q  <= (state_d == S_IDLE) || (state_d == S_COUNT) || (state_d == S_HI) ||
                           (state_d == S_LO)   || (state_d == S_CSUM);
            pgrm_addr_q <= (state_d == S_WR_ADDR);
            pgrm_data_q <= (state_d == S_WR_DATA);
            core_rst_q  <= (state_d == S_START);
            done_q      <= (state_d == S_START);
        end
    end

    always_comb begin
        core_in = user_in;
        if (state_q == S_WR_ADDR)      core_in = {8'h00, addr_q};
        else if (state_q == S_WR_DATA) core_in = word_q;
    end

    assign rx_ready       = rx_ready_q;
    assign core_pgrm_addr = pgrm_addr_q;
    assign core_pgrm_data = pgrm_data_q;
    assign core_rst       = core_rst_q;
    assign done           = done_q;
    assign busy           = (state_q != S_IDLE);
    assign err            = err_q;

endmodule

// File: tb/tb_hmmm_loader.sv
// Self-checking bench for hmmm_loader: frame-level scoreboard of expected
// writes and start pulses, checked every cycle, plus directed literal checks.
module tb_hmmm_loader;

    localparam logic [7:0] HEADER = 8'hA5;
    localparam int         TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] user_in;
    logic [15:0] core_in;
    logic        core_pgrm_addr, core_pgrm_data, core_rst, busy, done, err;

    hmmm_loader #(.HEADER(HEADER), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .user_in(user_in), .core_in(core_in),
        .core_pgrm_addr(core_pgrm_addr), .core_pgrm_data(core_pgrm_data),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         exp_q[$];
    wr_t         log_q[$];
    int          exp_done = 0;
    int          n_done = 0;
    int          ready_low = 0;
    logic [15:0] frame_words [256];
    logic        started;
    logic        prev_addr = 1'b0;
    logic [7:0]  obs_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;

    // Per-cycle compare against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && started) begin
            if (prev_addr) check("data_follows_addr", {31'b0, core_pgrm_data}, 32'd1);
            if (core_pgrm_addr) begin
                check("addr_data_exclusive", {31'b0, core_pgrm_data}, 32'd0);
                check("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("addr_value", {16'b0, core_in}, {24'b0, exp_q[0].addr});
                obs_addr = core_in[7:0];
            end else if (core_pgrm_data) begin
                check("data_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("data_value", {16'b0, core_in}, {16'b0, exp_q[0].data});
                    void'(exp_q.pop_front());
                end
                log_q.push_back('{addr: obs_addr, data: core_in});
            end else begin
                check("passthrough", {16'b0, core_in}, {16'b0, user_in});
            end
            check("rst_with_done", {31'b0, core_rst}, {31'b0, done});
            if (done) begin
                check("done_expected", {31'b0, exp_done > 0}, 32'd1);
                if (exp_done > 0) exp_done--;
                n_done++;
            end
            if (busy && !rx_ready && !done) ready_low++;
            prev_addr = core_pgrm_addr;
        end else begin
            prev_addr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a byte and returns 1 time unit after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        tick();
    endtask

    // Sends HEADER, CNT, CNT+1 words from frame_words and a checksum; scoreboards the outcome.
    task automatic send_frame(input logic [7:0] cnt, input bit force_csum, input logic [7:0] csum_val);
        logic [7:0] cs;
        logic [7:0] sent;
        cs = cnt;
        send_byte(HEADER);
        send_byte(cnt);
        for (int i = 0; i <= int'(cnt); i++) begin
            exp_q.push_back('{addr: 8'(i), data: frame_words[i]});
            send_byte(frame_words[i][15:8]);
            send_byte(frame_words[i][7:0]);
            cs = cs ^ frame_words[i][15:8] ^ frame_words[i][7:0];
        end
        sent = force_csum ? csum_val : cs;
        if (sent == cs) exp_done++;
        send_byte(sent);
        rx_valid = 1'b0;
    endtask

    initial begin
        int base, dbase;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        user_in  = 16'h0BAD;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_strobes", {30'b0, core_pgrm_addr, core_pgrm_data}, 32'd0);
        check("rst_flags", {29'b0, busy, done, err}, 32'd0);
        check("rst_core_in", {16'b0, core_in}, 32'h0BAD);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("held_core_rst", {31'b0, core_rst}, 32'd1);
        tick();
        check("release_core_rst", {31'b0, core_rst}, 32'd0);
        check("release_rx_ready", {31'b0, rx_ready}, 32'd1);

        // Valid 2-word frame with literal timing and values.
        base = log_q.size();
        dbase = n_done;
        exp_q.push_back('{addr: 8'h00, data: 16'h1F64});
        exp_q.push_back('{addr: 8'h01, data: 16'h0101});
        exp_done++;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h1F); send_byte(8'h64);
        check("wr_addr_strobe", {31'b0, core_pgrm_addr}, 32'd1);
        check("wr_addr_value", {16'b0, core_in}, 32'h0000);
        check("wr_addr_ready", {31'b0, rx_ready}, 32'd0);
        tick();
        check("wr_data_strobe", {30'b0, core_pgrm_addr, core_pgrm_data}, 32'd1);
        check("wr_data_value", {16'b0, core_in}, 32'h1F64);
        tick();
        check("after_word_ready", {30'b0, rx_ready, core_pgrm_data}, 32'd2);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h7A);
        rx_valid = 1'b0;
        check("start_pulse", {29'b0, core_rst, done, busy}, 32'd7);
        tick();
        check("after_start", {28'b0, core_rst, done, busy, err}, 32'd0);
        check("t1_writes", log_q.size() - base, 32'd2);
        if (log_q.size() >= base + 2) begin
            check("t1_w0", {8'b0, log_q[base].addr, log_q[base].data}, 32'h00_1F64);
            check("t1_w1", {8'b0, log_q[base+1].addr, log_q[base+1].data}, 32'h01_0101);
        end
        check("t1_done", n_done - dbase, 32'd1);

        // Bad checksum, then recovery.
        base = log_q.size();
        dbase = n_done;
        frame_words[0] = 16'h1234;
        send_frame(8'h00, 1'b1, 8'h00);
        repeat (2) tick();
        check("bad_err", {30'b0, err, busy}, 32'd2);
        check("bad_writes", log_q.size() - base, 32'd1);
        if (log_q.size() > base) check("bad_w0", {8'b0, log_q[base].addr, log_q[base].data}, 32'h00_1234);
        check("bad_no_done", n_done - dbase, 32'd0);
        frame_words[0] = 16'hCAFE;
        send_frame(8'h00, 1'b0, 8'h00);
        repeat (2) tick();
        check("recover_err", {31'b0, err}, 32'd0);
        check("recover_done", n_done - dbase, 32'd1);

        // Garbage before header.
        base = log_q.size();
        dbase = n_done;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        rx_valid = 1'b0;
        check("garbage_idle", {31'b0, busy}, 32'd0);
        frame_words[0] = 16'h0042;
        send_frame(8'h00, 1'b0, 8'h00);
        repeat (2) tick();
        check("garbage_writes", log_q.size() - base, 32'd1);
        check("garbage_done", n_done - dbase, 32'd1);

        // Maximum frame, rx_valid held throughout.
        base = log_q.size();
        dbase = n_done;
        for (int i = 0; i < 256; i++) frame_words[i] = 16'(i);
        ready_low = 0;
        send_frame(8'hFF, 1'b0, 8'h00);
        repeat (2) tick();
        check("max_writes", log_q.size() - base, 32'd256);
        if (log_q.size() > 0)
            check("max_last", {8'b0, log_q[log_q.size()-1].addr, log_q[log_q.size()-1].data}, 32'hFF_00FF);
        check("max_ready_low", ready_low, 32'd512);
        check("max_done", n_done - dbase, 32'd1);

        // Timeout after the HI byte.
        send_byte(HEADER); send_byte(8'h00); send_byte(8'h12);
        rx_valid = 1'b0;
        repeat (TMO - 1) tick();
        check("pre_timeout", {30'b0, err, busy}, 32'd1);
        tick();
        check("timeout", {30'b0, err, busy}, 32'd2);

        // Reset asserted while an address strobe is in flight.
        send_byte(HEADER); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD);
        rx_valid = 1'b0;
        check("inflight_addr", {31'b0, core_pgrm_addr}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_core_rst", {31'b0, core_rst}, 32'd1);
        check("midrst_strobes", {30'b0, core_pgrm_addr, core_pgrm_data}, 32'd0);
        check("midrst_flags", {28'b0, rx_ready, busy, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst_release", {30'b0, core_rst, rx_ready}, 32'd1);

        // Passthrough in IDLE and during HI.
        user_in = 16'd42;
        #1;
        check("pass_idle", {16'b0, core_in}, 32'd42);
        send_byte(HEADER); send_byte(8'h00);
        user_in = 16'h1234;
        #1;
        check("pass_hi", {16'b0, core_in, 15'b0, busy}, {16'h1234, 16'h0001});
        exp_q.push_back('{addr: 8'h00, data: 16'h5566});
        exp_done++;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h33);
        rx_valid = 1'b0;
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("done_all_seen", exp_done, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hmmm_loader.md
# hmmm_loader

Upstream program-load stage for the `hmmm` core. Accepts a framed byte stream from the board's serial receiver and converts it into the core's two-strobe programming sequence: address on `in` with `pgrm_addr`, then word on `in` with `pgrm_data`. On a verified frame it pulses the core's reset to start execution. Outside a load, it passes the user data input straight through to the core's `in` bus.

## Interface
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, 100000: maximum idle cycles between bytes inside a frame; ≥2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte. Transfer occurs on a rising edge with `rx_valid & rx_ready`.
- `user_in`  in  16  run-time data for the core.
- `core_in`  out  16  drives core `in`.
- `core_pgrm_addr`  out  1  drives core `pgrm_addr`.
- `core_pgrm_data`  out  1  drives core `pgrm_data`.
- `core_rst`  out  1  drives core `rst` (active-high).
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when a frame is accepted.
- `err`  out  1  sticky error flag.

## Operation
- **Frame format:** `HEADER`, `CNT`, then `CNT+1` words, then `CSUM`.
  - Words are sent high byte first; a frame carries 1..256 words.
  - `CSUM` = XOR of `CNT` and every data byte.
- **States:** IDLE, COUNT, HI, LO, WR_ADDR, WR_DATA, CSUM, START.
- **IDLE:** `rx_ready`=1. Bytes other than `HEADER` are discarded. On `HEADER`, clear `err` and go to COUNT.
- **COUNT:** latch `CNT`, set addr=0, seed checksum = `CNT`, go to HI.
- **HI / LO:** latch the byte into the word register and XOR it into the checksum. After LO, go to WR_ADDR.
- **WR_ADDR:**
  - `rx_ready`=0, `core_pgrm_addr`=1, `core_in`={8'h00, addr}.
  - Go to WR_DATA.
- **WR_DATA:**
  - `rx_ready`=0, `core_pgrm_data`=1, `core_in`=word.
  - If addr==`CNT`, go to CSUM; else addr+1 and go to HI.
  - addr is 8 bits; no increment past 255 because `CNT`≤255.
- **CSUM:**
  - On a match, go to START.
  - On a mismatch, set `err` and go to IDLE; `core_rst` is not pulsed.
  - Words already written remain in core memory.
- **START:** `rx_ready`=0, `core_rst`=1, `done`=1 for exactly one cycle, then IDLE.
- **Timeout:**
  - An idle counter runs in COUNT, HI, LO and CSUM. It clears on each accepted byte and on entry to those states.
  - On reaching `TIMEOUT_CYCLES`: set `err`, go to IDLE.
- **`core_in` mux:**
  - In WR_ADDR and WR_DATA, `core_in` is the registered programming value.
  - In all other states, `core_in`=`user_in`, combinational passthrough.
- **`busy`** = 1 in every state except IDLE.

## Timing
- **Reset values:**
  - `rx_ready`=0, `core_pgrm_addr`=0, `core_pgrm_data`=0, `core_rst`=1.
  - `busy`=0, `done`=0, `err`=0.
  - State=IDLE, counters=0.
  - `core_in` follows `user_in`.
- **First clock after `rst_n` deasserts:** `core_rst`→0 and `rx_ready`→1. This holds the core in reset for the entire loader reset.
- **Strobe outputs** are registered. Each of `core_pgrm_addr`, `core_pgrm_data`, `core_rst` and `done` is high for exactly one cycle per event.
- **Per-word sequence:**
  - The cycle after the LO byte is accepted: WR_ADDR.
  - The next cycle: WR_DATA.
  - The next cycle: HI/CSUM with `rx_ready`=1.
  - Minimum word period is 4 cycles.
- **Frame end:** START occurs the cycle after the `CSUM` byte is accepted.
- **`rx_valid` while `rx_ready`=0:** the byte is held by the source and not consumed.
- **`rst_n` asserted mid-frame:**
  - Immediate abort; all outputs take reset values, including `core_rst`=1.
  - Any strobe in flight is dropped.
- **`HEADER` value inside a frame** is treated as data, not as a resync.

## Test plan
- **Valid 2-word frame:** send A5 01 1F 64 01 01 7A.
  - Expect `core_pgrm_addr` with `core_in`=0x0000, then `core_pgrm_data` with 0x1F64.
  - Then 0x0001 / 0x0101.
  - Then one-cycle `core_rst` and `done`; `err`=0.
- **Bad checksum:** send A5 00 12 34 00.
  - Expect one write of 0x1234 to addr 0.
  - `err`=1, no `core_rst` pulse, returns to IDLE.
  - A following valid frame clears `err`.
- **Garbage before header:** send 00 FF 5A, then a valid 1-word frame.
  - The first three bytes are ignored; exactly one write; `done` pulse.
- **Max frame:** `CNT`=FF, 256 words with data=addr.
  - Expect the last write at addr 0x00FF with data 0x00FF, then `done`.
  - `rx_valid` held high throughout; `rx_ready` drops 2 cycles per word.
- **Timeout and reset:**
  - With `TIMEOUT_CYCLES`=16, stall after the HI byte. Expect `err`=1 after 16 idle cycles and `busy`=0.
  - Separately, assert `rst_n` mid-word. Expect `core_rst`=1 and strobes cleared immediately.
- **Passthrough:** in IDLE, `user_in`=42. Expect `core_in`=42 in the same cycle; also during HI.
